uart_boot_loader: RTL

Receives a program image over the SoC UART receive line and writes it word-by-word into instruction memory. It holds the core in reset until the image is loaded. The block sits between the `uart_rx` pad and the instruction-memory write port. It consumes the 8N1 byte stream produced by the host or bench, and assembles the bytes into 32-bit little-endian instructions.

---
 rtl/uart_boot_loader.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an 8N1 byte stream, assembles little-endian
// 32-bit words, takes the first word as the image length in words and
// writes the following words into instruction memory. The core is held in
// reset until the whole image has been written.
module uart_boot_loader #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              uart_rx_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    output logic              boot_done_o,
    output logic              core_rst_o,
    output logic              frame_err_o,
    output logic              overrun_err_o,
    output logic              len_err_o
);

    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB + 1);

    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CPB - 1);
    localparam logic [32:0]       DEPTH    = 33'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        L_LEN,
        L_DATA,
        L_WRITE,
        L_DONE,
        L_ERR
    } ld_state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic             rx_meta_reg;
    logic             rx_sync_reg;

    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             byte_valid_reg, byte_valid_next;
    logic             frame_err_reg, frame_err_next;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx_i;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state_reg   <= RX_IDLE;
            cnt_reg        <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_state_reg   <= rx_state_next;
            cnt_reg        <= cnt_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // Receiver next state: mid-bit sampling, LSB first, stop-bit check.
    always_comb begin
        rx_state_next   = rx_state_reg;
        cnt_next        = cnt_reg + CNT_W'(1);
        bit_next        = bit_reg;
        shift_next      = shift_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = frame_err_reg;
        case (rx_state_reg)
            RX_IDLE: begin
                cnt_next = '0;
                if (!rx_sync_reg) begin
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    bit_next = '0;
                    // A line that is high again at mid start bit was a glitch.
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync_reg, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next = '0;
                    if (rx_sync_reg) begin
                        byte_valid_next = 1'b1;
                        rx_state_next   = RX_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        rx_state_next  = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                cnt_next = '0;
                if (rx_sync_reg) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: begin
                rx_state_next = RX_IDLE;
                cnt_next      = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    ld_state_t        ld_state_reg, ld_state_next;
    logic [1:0]       byte_idx_reg, byte_idx_next;
    logic [31:0]      word_reg, word_next;
    logic [31:0]      len_reg, len_next;
    logic [ADDR_W:0]  idx_reg, idx_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic             len_err_reg, len_err_next;
    logic             overrun_err_reg, overrun_err_next;

    logic [31:0]      assembled;
    logic [ADDR_W:0]  idx_inc;

    // Loader state and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ld_state_reg    <= L_LEN;
            byte_idx_reg    <= '0;
            word_reg        <= '0;
            len_reg         <= '0;
            idx_reg         <= '0;
            wdata_reg       <= '0;
            len_err_reg     <= 1'b0;
            overrun_err_reg <= 1'b0;
        end else begin
            ld_state_reg    <= ld_state_next;
            byte_idx_reg    <= byte_idx_next;
            word_reg        <= word_next;
            len_reg         <= len_next;
            idx_reg         <= idx_next;
            wdata_reg       <= wdata_next;
            len_err_reg     <= len_err_next;
            overrun_err_reg <= overrun_err_next;
        end
    end

    // Loader next state: byte assembly, length decode and write handshake.
    always_comb begin
        ld_state_next    = ld_state_reg;
        byte_idx_next    = byte_idx_reg;
        word_next        = word_reg;
        len_next         = len_reg;
        idx_next         = idx_reg;
        wdata_next       = wdata_reg;
        len_err_next     = len_err_reg;
        overrun_err_next = overrun_err_reg;

        assembled = word_reg;
        assembled[8*byte_idx_reg +: 8] = shift_reg;
        idx_inc = idx_reg + {{ADDR_W{1'b0}}, 1'b1};

        case (ld_state_reg)
            L_LEN, L_DATA: begin
                if (byte_valid_reg) begin
                    word_next     = assembled;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        if (ld_state_reg == L_LEN) begin
                            len_next = assembled;
                            if (assembled == 32'd0) begin
                                ld_state_next = L_DONE;
                            end else if ({1'b0, assembled} > DEPTH) begin
                                len_err_next  = 1'b1;
                                ld_state_next = L_ERR;
                            end else begin
                                ld_state_next = L_DATA;
                            end
                        end else begin
                            wdata_next    = assembled;
                            ld_state_next = L_WRITE;
                        end
                    end
                end
            end
            L_WRITE: begin
                // The assembly buffer is busy; a new byte cannot be kept.
                if (byte_valid_reg) begin
                    overrun_err_next = 1'b1;
                end
                if (mem_gnt_i) begin
                    idx_next = idx_inc;
                    if (32'(idx_inc) == len_reg) begin
                        ld_state_next = L_DONE;
                    end else begin
                        ld_state_next = L_DATA;
                    end
                end
            end
            L_DONE, L_ERR: begin
                ld_state_next = ld_state_reg;
            end
            default: begin
                ld_state_next = L_LEN;
            end
        endcase
    end

    // Outputs decoded from registered state; address/data zero outside writes.
    always_comb begin
        mem_req_o     = (ld_state_reg == L_WRITE);
        mem_we_o      = mem_req_o;
        mem_addr_o    = mem_req_o ? (BASE + idx_reg[ADDR_W-1:0]) : '0;
        mem_wdata_o   = mem_req_o ? wdata_reg : 32'd0;
        boot_done_o   = (ld_state_reg == L_DONE);
        core_rst_o    = !boot_done_o;
        frame_err_o   = frame_err_reg;
        overrun_err_o = overrun_err_reg;
        len_err_o     = len_err_reg;
    end

endmodule
